// File: rtl/baser_pkg.sv
// Shared definitions for the 64b/66b to 256b/257b transcoding path:
// widths, sync headers, control block types and small helper functions.
package baser_pkg;

    localparam int DATA_WIDTH        = 64;
    localparam int HDR_WIDTH         = 2;
    localparam int FRAME_WIDTH       = DATA_WIDTH + HDR_WIDTH;
    localparam int TC_WIDTH          = 257;
    localparam int TRANSCODER_BLOCKS = 4;
    localparam int CNT_WIDTH         = 32;

    localparam logic [HDR_WIDTH-1:0] SH_DATA = 2'b01;
    localparam logic [HDR_WIDTH-1:0] SH_CTRL = 2'b10;

    // Legal control block types; their high nibbles are all distinct.
    localparam logic [7:0] BT_1E = 8'h1E;
    localparam logic [7:0] BT_2D = 8'h2D;
    localparam logic [7:0] BT_33 = 8'h33;
    localparam logic [7:0] BT_4B = 8'h4B;
    localparam logic [7:0] BT_55 = 8'h55;
    localparam logic [7:0] BT_66 = 8'h66;
    localparam logic [7:0] BT_78 = 8'h78;
    localparam logic [7:0] BT_87 = 8'h87;
    localparam logic [7:0] BT_99 = 8'h99;
    localparam logic [7:0] BT_AA = 8'hAA;
    localparam logic [7:0] BT_B4 = 8'hB4;
    localparam logic [7:0] BT_CC = 8'hCC;
    localparam logic [7:0] BT_D2 = 8'hD2;
    localparam logic [7:0] BT_E1 = 8'hE1;
    localparam logic [7:0] BT_FF = 8'hFF;

    typedef logic [FRAME_WIDTH-1:0] block_t;

    typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2, SLOT3} slot_e;

    function automatic logic type_valid(input logic [7:0] t);
        case (t)
            BT_1E, BT_2D, BT_33, BT_4B, BT_55, BT_66, BT_78, BT_87,
            BT_99, BT_AA, BT_B4, BT_CC, BT_D2, BT_E1, BT_FF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic sh_invalid(input block_t b);
        return (b[FRAME_WIDTH-1 -: HDR_WIDTH] != SH_DATA) &&
               (b[FRAME_WIDTH-1 -: HDR_WIDTH] != SH_CTRL);
    endfunction

    // Type checking applies to genuine control blocks; a bad sync header is flagged on its own.
    function automatic logic type_invalid(input block_t b);
        return (b[FRAME_WIDTH-1 -: HDR_WIDTH] == SH_CTRL) && !type_valid(b[63:56]);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                     input logic en);
        return (en && (c != '1)) ? c + CNT_WIDTH'(1) : c;
    endfunction

endpackage

// File: rtl/baser_257b_encode_comb.sv
// Combinational mapping of four 66b blocks (index 0 first) onto one 257b
// transcoded block, plus an error flag for bad headers or block types.
module baser_257b_encode_comb
    import baser_pkg::*;
(
    input  block_t [TRANSCODER_BLOCKS-1:0] blocks,
    output logic   [TC_WIDTH-1:0]          xcoded,
    output logic                           err
);

    logic [255:0] acc;
    logic [3:0]   dmask;
    logic         seen_ctrl;

    // Payloads are shifted in oldest first; the first control block drops its type low nibble.
    always_comb begin
        acc       = '0;
        dmask     = '0;
        seen_ctrl = 1'b0;
        err       = 1'b0;
        for (int i = 0; i < TRANSCODER_BLOCKS; i++) begin
            dmask[3-i] = (blocks[i][65:64] == SH_DATA);
            err        = err | sh_invalid(blocks[i]) | type_invalid(blocks[i]);
            if (dmask[3-i] || seen_ctrl) begin
                acc = {acc[191:0], blocks[i][63:0]};
            end else begin
                acc       = {acc[195:0], blocks[i][63:60], blocks[i][55:0]};
                seen_ctrl = 1'b1;
            end
        end
        xcoded = (&dmask) ? {1'b1, acc} : {1'b0, dmask, acc[251:0]};
    end

endmodule

// File: rtl/baser_257b_transcoder.sv
// Transmit 256b/257b transcoder: collects four accepted 66b blocks, emits one
// registered 257b block with valid/ready, and keeps saturating statistics.
module baser_257b_transcoder
    import baser_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic [FRAME_WIDTH-1:0] i_coded,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_align,
    output logic [TC_WIDTH-1:0]    o_xcoded,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_err,
    output logic [CNT_WIDTH-1:0]   o_block_count,
    output logic [CNT_WIDTH-1:0]   o_ctrl_count,
    output logic [CNT_WIDTH-1:0]   o_inv_sh_count,
    output logic [CNT_WIDTH-1:0]   o_inv_type_count
);

    // Handshake: a word moves on either side only in a cycle where valid && ready.
    slot_e                         state, next_state;
    logic                          accept, group_done;
    logic [1:0]                    wr_slot;
    block_t [2:0]                  buf_q;
    block_t [TRANSCODER_BLOCKS-1:0] group;
    logic [TC_WIDTH-1:0]           enc_xcoded;
    logic                          enc_err;

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state <= SLOT0;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (i_align)     next_state = accept ? SLOT1 : SLOT0;
        else if (accept) next_state = slot_e'(state + 2'd1);
    end

    always_comb begin
        wr_slot    = i_align ? 2'd0 : state;
        group_done = accept && !i_align && (state == SLOT3);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            buf_q <= '0;
        end else if (accept) begin
            case (wr_slot)
                2'd0:    buf_q[0] <= i_coded;
                2'd1:    buf_q[1] <= i_coded;
                2'd2:    buf_q[2] <= i_coded;
                default: ;
            endcase
        end
    end

    // The fourth block is taken straight from the input so it encodes in its accept cycle.
    assign group = {i_coded, buf_q[2], buf_q[1], buf_q[0]};

    baser_257b_encode_comb u_encode (
        .blocks (group),
        .xcoded (enc_xcoded),
        .err    (enc_err)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_xcoded <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
        end else if (group_done) begin
            o_xcoded <= enc_xcoded;
            o_valid  <= 1'b1;
            o_err    <= enc_err;
        end else if (i_ready) begin
            o_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_block_count    <= '0;
            o_ctrl_count     <= '0;
            o_inv_sh_count   <= '0;
            o_inv_type_count <= '0;
        end else begin
            o_block_count    <= sat_inc(o_block_count, group_done);
            o_ctrl_count     <= sat_inc(o_ctrl_count, group_done && !enc_xcoded[256]);
            o_inv_sh_count   <= sat_inc(o_inv_sh_count, accept && sh_invalid(i_coded));
            o_inv_type_count <= sat_inc(o_inv_type_count, accept && type_invalid(i_coded));
        end
    end

endmodule

// File: tb/tb_baser_257b_transcoder.sv
// Bench for the 256b/257b transcoder: vector table of groups, random data
// groups under random backpressure, hold, realign and mid-group reset.
module tb_baser_257b_transcoder;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [65:0]  i_coded;
    logic         i_valid;
    logic         o_ready;
    logic         i_align;
    logic [256:0] o_xcoded;
    logic         o_valid;
    logic         i_ready;
    logic         o_err;
    logic [31:0]  o_block_count, o_ctrl_count, o_inv_sh_count, o_inv_type_count;

    always #5 clk = ~clk;

    baser_257b_transcoder dut (
        .clk              (clk),
        .i_rst            (i_rst),
        .i_coded          (i_coded),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_align          (i_align),
        .o_xcoded         (o_xcoded),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_err            (o_err),
        .o_block_count    (o_block_count),
        .o_ctrl_count     (o_ctrl_count),
        .o_inv_sh_count   (o_inv_sh_count),
        .o_inv_type_count (o_inv_type_count)
    );

    typedef struct packed {
        logic [3:0][65:0] blk;
        logic [256:0]     exp;
        logic             err;
        logic [1:0]       n_sh;
        logic [1:0]       n_type;
    } vec_t;

    localparam logic [63:0] PA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PB = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] PC = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [63:0] PI = 64'h1E00_0000_0000_0000;
    localparam logic [63:0] PAA = 64'hAAAA_AAAA_AAAA_AAAA;

    vec_t         vecs[7];
    logic [257:0] exp_q[$];
    logic [257:0] mon_e;
    int           checks = 0, errors = 0;
    int           words_seen = 0, pushed = 0;
    int           exp_blocks = 0, exp_ctrl = 0, exp_inv_sh = 0, exp_inv_type = 0;
    logic         rand_rdy = 1'b0;

    function automatic logic [65:0] dblk(input logic [63:0] p); return {2'b01, p}; endfunction
    function automatic logic [65:0] cblk(input logic [63:0] p); return {2'b10, p}; endfunction

    function automatic vec_t mk(input logic [65:0] b0, input logic [65:0] b1,
                                input logic [65:0] b2, input logic [65:0] b3,
                                input logic [256:0] e, input logic er,
                                input logic [1:0] nsh, input logic [1:0] nty);
        vec_t v;
        v.blk[0] = b0; v.blk[1] = b1; v.blk[2] = b2; v.blk[3] = b3;
        v.exp = e; v.err = er; v.n_sh = nsh; v.n_type = nty;
        return v;
    endfunction

    task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Output side of the scoreboard: a transfer happens at the next posedge.
    always @(negedge clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_word actual=%h expected=none", o_xcoded);
            end else begin
                mon_e = exp_q.pop_front();
                check("word", o_xcoded, mon_e[256:0]);
                check("word_err", 257'(o_err), 257'(mon_e[257]));
                words_seen++;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_block(input logic [65:0] blk, input logic align);
        logic acc;
        int   n;
        i_coded = blk; i_valid = 1'b1; i_align = align;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk); #1;
            n++;
        end
        i_valid = 1'b0; i_align = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic push_exp(input logic [256:0] e, input logic er);
        exp_q.push_back({er, e});
        pushed++;
        exp_blocks++;
        if (!e[256]) exp_ctrl++;
    endtask

    task automatic send_group(input vec_t v);
        push_exp(v.exp, v.err);
        exp_inv_sh   += int'(v.n_sh);
        exp_inv_type += int'(v.n_type);
        for (int i = 0; i < 4; i++) send_block(v.blk[i], 1'b0);
    endtask

    task automatic check_counters();
        repeat (3) @(posedge clk);
        #1;
        check("block_count", 257'(o_block_count), 257'(exp_blocks));
        check("ctrl_count", 257'(o_ctrl_count), 257'(exp_ctrl));
        check("inv_sh_count", 257'(o_inv_sh_count), 257'(exp_inv_sh));
        check("inv_type_count", 257'(o_inv_type_count), 257'(exp_inv_type));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 257'(o_valid), 257'(0));
        check({tag, "_xcoded"}, o_xcoded, 257'(0));
        check({tag, "_err"}, 257'(o_err), 257'(0));
        check({tag, "_ready"}, 257'(o_ready), 257'(1));
        check({tag, "_counts"}, 257'({o_block_count, o_ctrl_count, o_inv_sh_count, o_inv_type_count}),
              257'(0));
    endtask

    initial begin
        vecs[0] = mk(dblk(PAA), dblk(PAA), dblk(PAA), dblk(PAA),
                     {1'b1, PAA, PAA, PAA, PAA}, 1'b0, 2'd0, 2'd0);
        vecs[1] = mk(cblk(PI), cblk(PI), cblk(PI), cblk(PI),
                     {1'b0, 4'b0000, 4'h1, 56'h0, PI, PI, PI}, 1'b0, 2'd0, 2'd0);
        vecs[2] = mk(dblk(PA), cblk(64'h7811_2233_4455_6677), dblk(PB), dblk(PC),
                     {1'b0, 4'b1011, PA, 4'h7, 56'h11_2233_4455_6677, PB, PC}, 1'b0, 2'd0, 2'd0);
        vecs[3] = mk(dblk(PA), cblk(64'h5A00_0000_0000_00FF), {2'b11, 64'h1E00_0000_0000_0001}, dblk(PB),
                     {1'b0, 4'b1001, PA, 4'h5, 56'h00_0000_0000_00FF, 64'h1E00_0000_0000_0001, PB},
                     1'b1, 2'd1, 2'd1);
        vecs[4] = mk(dblk(PA), dblk(PB), dblk(PC), cblk(64'hFF01_0203_0405_0607),
                     {1'b0, 4'b1110, PA, PB, PC, 4'hF, 56'h01_0203_0405_0607}, 1'b0, 2'd0, 2'd0);
        vecs[5] = mk({2'b00, 64'h8712_3456_789A_BCDE}, dblk(PA), cblk(64'h99AA_BBCC_DDEE_FF00), dblk(PB),
                     {1'b0, 4'b0101, 4'h8, 56'h12_3456_789A_BCDE, PA, 64'h99AA_BBCC_DDEE_FF00, PB},
                     1'b1, 2'd1, 2'd0);
        vecs[6] = mk(dblk(PA), cblk(PI), cblk(64'h0000_0000_0000_0001), dblk(PB),
                     {1'b0, 4'b1001, PA, 4'h1, 56'h0, 64'h0000_0000_0000_0001, PB}, 1'b1, 2'd0, 2'd1);

        // Clock/reset
        i_rst = 1'b1; i_valid = 1'b0; i_align = 1'b0; i_ready = 1'b1; i_coded = '0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("reset");

        // Table of groups
        for (int k = 0; k < 7; k++) begin
            send_group(vecs[k]);
            check_counters();
        end

        // Random all-data groups under random backpressure
        rand_rdy = 1'b1;
        for (int g = 0; g < 6; g++) begin
            logic [3:0][63:0] p;
            for (int i = 0; i < 4; i++) p[i] = {$urandom, $urandom};
            push_exp({1'b1, p[0], p[1], p[2], p[3]}, 1'b0);
            for (int i = 0; i < 4; i++) send_block(dblk(p[i]), 1'b0);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2 i_ready = 1'b1;
        drain();
        check_counters();

        // Hold the output for 10 cycles
        i_ready = 1'b0;
        send_group(vecs[1]);
        fork
            send_group(vecs[2]);
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("hold_ready", 257'(o_ready), 257'(0));
                    check("hold_valid", 257'(o_valid), 257'(1));
                    check("hold_word", o_xcoded, vecs[1].exp);
                end
                @(posedge clk); #1 i_ready = 1'b1;
            end
        join
        drain();
        check_counters();

        // Realign with a simultaneous accept, then realign while idle
        send_block(dblk(PB), 1'b0);
        send_block(dblk(PC), 1'b0);
        push_exp({1'b1, PA, PAA, PI, PC}, 1'b0);
        send_block(dblk(PA), 1'b1);
        send_block(dblk(PAA), 1'b0);
        send_block(dblk(PI), 1'b0);
        send_block(dblk(PC), 1'b0);
        for (int i = 0; i < 3; i++) send_block(dblk(PB), 1'b0);
        i_align = 1'b1;
        @(posedge clk); #1 i_align = 1'b0;
        push_exp({1'b1, PC, PB, PA, PI}, 1'b0);
        send_block(dblk(PC), 1'b0);
        send_block(dblk(PB), 1'b0);
        send_block(dblk(PA), 1'b0);
        send_block(dblk(PI), 1'b0);
        drain();
        check_counters();
        check("words_seen", 257'(words_seen), 257'(pushed));

        // Reset in the middle of a group
        send_block(cblk(PI), 1'b0);
        send_block(dblk(PB), 1'b0);
        i_rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state("midrst");
        i_rst = 1'b0;
        exp_blocks = 0; exp_ctrl = 0; exp_inv_sh = 0; exp_inv_type = 0;
        @(posedge clk); #1;
        send_group(vecs[0]);
        drain();
        check_counters();
        check("final_words_seen", 257'(words_seen), 257'(pushed));
        check("queue_empty", 257'(exp_q.size()), 257'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
